// File: rtl/neural_pkg.sv
// Shared defaults and types for the multi-channel neural front end:
// channel/sample defaults, scheduler state encoding, frame counter width.
package neural_pkg;
    localparam int NCH_DEF = 4;
    localparam int DW_DEF  = 16;
    localparam int FCW     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker, zero latency: searches from i_last+1 (mod NCH)
// and returns the first requester as one-hot plus index; no handshake of its own.
module rr_arbiter
    import neural_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CHW = $clog2(NCH)
) (
    input  logic [NCH-1:0] i_req,
    input  logic [CHW-1:0] i_last,
    output logic [NCH-1:0] o_grant,
    output logic [CHW-1:0] o_idx,
    output logic           o_any
);
    int w_c;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_c     = 0;
        for (int k = 1; k <= NCH; k++) begin
            w_c = (int'(i_last) + k) % NCH;
            if (!o_any && i_req[w_c]) begin
                o_any        = 1'b1;
                o_grant[w_c] = 1'b1;
                o_idx        = CHW'(w_c);
            end
        end
    end
endmodule

// File: rtl/channel_scheduler.sv
// Per-channel holding slots merged round-robin onto one pipeline port; 2 cycles from
// slot load to pipe_valid. Output register stalls on !pipe_ready; slots refill when empty.
module channel_scheduler
    import neural_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int DW  = DW_DEF,
    parameter int CHW = $clog2(NCH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [NCH-1:0]    i_ch_enable,
    input  logic [NCH-1:0]    i_ch_valid,
    input  logic [NCH*DW-1:0] i_ch_data,
    output logic [NCH-1:0]    o_ch_ready,
    output logic              o_pipe_valid,
    output logic [DW-1:0]     o_pipe_data,
    output logic [CHW-1:0]    o_pipe_chan,
    input  logic              i_pipe_ready,
    output logic              o_frame_done,
    output logic [FCW-1:0]    o_frame_count,
    output logic              o_busy
);
    state_t         r_state;
    logic [NCH-1:0] r_full;
    logic [DW-1:0]  r_slot [NCH];
    logic [NCH-1:0] r_served;
    logic [CHW-1:0] r_last;
    logic           r_pipe_valid;
    logic [DW-1:0]  r_pipe_data;
    logic [CHW-1:0] r_pipe_chan;
    logic           r_frame_done;
    logic [FCW-1:0] r_frame_count;

    logic           w_active;
    logic           w_can_grant;
    logic           w_any;
    logic           w_frame_cmp;
    logic [NCH-1:0] w_req;
    logic [NCH-1:0] w_grant;
    logic [NCH-1:0] w_served_nxt;
    logic [CHW-1:0] w_idx;

    assign w_active    = (r_state != IDLE);
    assign w_can_grant = w_active && (!r_pipe_valid || i_pipe_ready);
    assign w_req       = r_full & i_ch_enable & {NCH{w_can_grant}};
    assign o_ch_ready  = (r_state == RUN) ? (i_ch_enable & ~r_full) : '0;

    rr_arbiter #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_arb (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Served mask is re-masked by the live enable so dropping a channel mid-frame
    // neither blocks nor falsely completes the frame.
    assign w_served_nxt = (r_served | w_grant) & i_ch_enable;
    assign w_frame_cmp  = w_active && (i_ch_enable != '0) && (w_served_nxt == i_ch_enable);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!i_ch_enable[i] || w_grant[i]) begin
                    r_full[i] <= 1'b0;
                end else if (i_ch_valid[i] && o_ch_ready[i]) begin
                    r_full[i] <= 1'b1;
                    r_slot[i] <= i_ch_data[i*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe_valid <= 1'b0;
            r_pipe_data  <= '0;
            r_pipe_chan  <= '0;
        end else if (w_any) begin
            r_pipe_valid <= 1'b1;
            r_pipe_data  <= r_slot[w_idx];
            r_pipe_chan  <= w_idx;
        end else if (i_pipe_ready) begin
            r_pipe_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_served      <= '0;
            r_last        <= CHW'(NCH - 1);
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_done <= w_frame_cmp;
            if (w_frame_cmp) begin
                r_frame_count <= r_frame_count + FCW'(1);
            end
            if (w_any) begin
                r_last <= w_idx;
            end
            if (!w_active || w_frame_cmp) begin
                r_served <= '0;
            end else begin
                r_served <= w_served_nxt;
            end
            case (r_state)
                IDLE:    if (i_start) r_state <= RUN;
                RUN:     if (i_stop) r_state <= DRAIN;
                DRAIN:   if ((r_full == '0) && !r_pipe_valid) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_pipe_valid  = r_pipe_valid;
    assign o_pipe_data   = r_pipe_data;
    assign o_pipe_chan   = r_pipe_chan;
    assign o_frame_done  = r_frame_done;
    assign o_frame_count = r_frame_count;
    assign o_busy        = w_active;
endmodule

// File: tb/tb_channel_scheduler.sv
// Directed bench for channel_scheduler: cycle table for streaming, stall and
// enable-mask behaviour, then hand sequences for reset, drain and counter wrap.
module tb_channel_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, pr;
    logic [3:0]  en, vld;
    logic [63:0] data;
    logic [3:0]  rdy;
    logic        pv, fd, busy;
    logic [15:0] pdat, fc;
    logic [1:0]  pch;

    int checks = 0;
    int fails  = 0;
    logic [15:0] vals [4];
    logic [1:0]  got_ch [4];
    logic [15:0] got_dat [4];
    int n, lat, nfd;

    typedef struct {
        logic        start, stop;
        logic [3:0]  en, vld;
        logic        pr;
        logic [3:0]  x_rdy;
        logic        x_pv;
        logic [1:0]  x_ch;
        logic        x_fd;
        logic [15:0] x_fc;
        logic        x_busy;
    } vec_t;
    vec_t tbl [23];

    channel_scheduler #(.NCH(4), .DW(16), .CHW(2)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_stop        (stop),
        .i_ch_enable   (en),
        .i_ch_valid    (vld),
        .i_ch_data     (data),
        .o_ch_ready    (rdy),
        .o_pipe_valid  (pv),
        .o_pipe_data   (pdat),
        .o_pipe_chan   (pch),
        .i_pipe_ready  (pr),
        .o_frame_done  (fd),
        .o_frame_count (fc),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int st, input int sp, input int e, input int v, input int p,
                                input int rd, input int pvv, input int ch, input int f,
                                input int c, input int b);
        vec_t t;
        t.start  = st[0];
        t.stop   = sp[0];
        t.en     = e[3:0];
        t.vld    = v[3:0];
        t.pr     = p[0];
        t.x_rdy  = rd[3:0];
        t.x_pv   = pvv[0];
        t.x_ch   = ch[1:0];
        t.x_fd   = f[0];
        t.x_fc   = c[15:0];
        t.x_busy = b[0];
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic load_data();
        for (int i = 0; i < 4; i++) data[i*16 +: 16] = vals[i];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; en = 4'h0; vld = 4'h0; pr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; en = 4'h0; vld = 4'h0; pr = 1'b0;
        vals[0] = 16'd100; vals[1] = 16'(-200); vals[2] = 16'd300; vals[3] = 16'(-400);
        load_data();

        //        st sp en   vld  pr  rdy  pv ch fd fc busy
        tbl[0]  = mk(1, 0, 'hF, 'hF, 1, 'h0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 'hF, 'hF, 1, 'hF, 0, 0, 0, 0, 1);
        tbl[2]  = mk(0, 0, 'hF, 'hF, 1, 'h0, 0, 0, 0, 0, 1);
        tbl[3]  = mk(0, 0, 'hF, 'hF, 1, 'h1, 1, 0, 0, 0, 1);
        tbl[4]  = mk(0, 0, 'hF, 'hF, 1, 'h2, 1, 1, 0, 0, 1);
        tbl[5]  = mk(0, 0, 'hF, 'hF, 1, 'h4, 1, 2, 0, 0, 1);
        tbl[6]  = mk(0, 0, 'hF, 'hF, 1, 'h8, 1, 3, 1, 1, 1);
        tbl[7]  = mk(0, 0, 'hF, 'hF, 1, 'h1, 1, 0, 0, 1, 1);
        tbl[8]  = mk(0, 0, 'hF, 'hF, 0, 'h2, 1, 1, 0, 1, 1);
        tbl[9]  = mk(0, 0, 'hF, 'hF, 0, 'h0, 1, 1, 0, 1, 1);
        tbl[10] = mk(0, 0, 'hF, 'hF, 0, 'h0, 1, 1, 0, 1, 1);
        tbl[11] = mk(0, 0, 'hF, 'hF, 0, 'h0, 1, 1, 0, 1, 1);
        tbl[12] = mk(0, 0, 'hF, 'hF, 0, 'h0, 1, 1, 0, 1, 1);
        tbl[13] = mk(0, 0, 'hF, 'hF, 1, 'h0, 1, 1, 0, 1, 1);
        tbl[14] = mk(0, 0, 'hF, 'hF, 1, 'h4, 1, 2, 0, 1, 1);
        tbl[15] = mk(0, 0, 'hF, 'hF, 1, 'h8, 1, 3, 1, 2, 1);
        tbl[16] = mk(0, 0, 'hF, 'hF, 1, 'h1, 1, 0, 0, 2, 1);
        tbl[17] = mk(0, 0, 'h5, 'h5, 1, 'h0, 1, 1, 0, 2, 1);
        tbl[18] = mk(0, 0, 'h5, 'h5, 1, 'h4, 1, 2, 1, 3, 1);
        tbl[19] = mk(0, 0, 'h5, 'h5, 1, 'h1, 1, 0, 0, 3, 1);
        tbl[20] = mk(0, 0, 'h5, 'h5, 1, 'h4, 1, 2, 1, 4, 1);
        tbl[21] = mk(0, 0, 'h5, 'h5, 1, 'h1, 1, 0, 0, 4, 1);
        tbl[22] = mk(0, 0, 'h5, 'h5, 1, 'h4, 1, 2, 1, 5, 1);

        #2;
        chk("rst_rdy",  0, 32'(rdy),  32'h0);
        chk("rst_pv",   0, 32'(pv),   32'h0);
        chk("rst_dat",  0, 32'(pdat), 32'h0);
        chk("rst_ch",   0, 32'(pch),  32'h0);
        chk("rst_fd",   0, 32'(fd),   32'h0);
        chk("rst_fc",   0, 32'(fc),   32'h0);
        chk("rst_busy", 0, 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 23; r++) begin
            @(negedge clk);
            start = tbl[r].start; stop = tbl[r].stop; en = tbl[r].en;
            vld = tbl[r].vld; pr = tbl[r].pr;
            #1;
            chk("tbl_rdy", r, 32'(rdy), 32'(tbl[r].x_rdy));
            chk("tbl_pv",  r, 32'(pv),  32'(tbl[r].x_pv));
            if (tbl[r].x_pv) begin
                chk("tbl_ch",  r, 32'(pch),  32'(tbl[r].x_ch));
                chk("tbl_dat", r, 32'(pdat), 32'(vals[tbl[r].x_ch]));
            end
            chk("tbl_fd",   r, 32'(fd),   32'(tbl[r].x_fd));
            chk("tbl_fc",   r, 32'(fc),   32'(tbl[r].x_fc));
            chk("tbl_busy", r, 32'(busy), 32'(tbl[r].x_busy));
        end

        // Asynchronous reset in the middle of a live stream.
        @(negedge clk);
        #1;
        chk("pre_rst_pv", 0, 32'(pv), 32'h1);
        chk("pre_rst_fc", 0, 32'(fc), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pv",   0, 32'(pv),   32'h0);
        chk("arst_fc",   0, 32'(fc),   32'h0);
        chk("arst_busy", 0, 32'(busy), 32'h0);
        chk("arst_rdy",  0, 32'(rdy),  32'h0);
        chk("arst_dat",  0, 32'(pdat), 32'h0);
        chk("arst_ch",   0, 32'(pch),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1; en = 4'hF; vld = 4'hF; pr = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (lat < 10) begin
            #1;
            if (pv) break;
            @(negedge clk);
            lat++;
        end
        chk("first_lat", 0, 32'(lat),  32'd2);
        chk("first_ch",  0, 32'(pch),  32'd0);
        chk("first_dat", 0, 32'(pdat), 32'(vals[0]));

        // Stop with three samples in flight: one in the output register, two held.
        do_reset();
        vals[0] = 16'h1234; vals[1] = 16'h7FFF; vals[2] = 16'h8000; vals[3] = 16'hFFFF;
        load_data();
        @(negedge clk);
        start = 1'b1; en = 4'hF; vld = 4'h0; pr = 1'b0;
        @(negedge clk);
        start = 1'b0; vld = 4'b1110;
        #1;
        chk("stop_rdy_a", 0, 32'(rdy), 32'hF);
        @(negedge clk);
        vld = 4'h0;
        #1;
        chk("stop_rdy_b", 0, 32'(rdy), 32'h1);
        @(negedge clk);
        stop = 1'b1;
        #1;
        chk("stop_rdy_c", 0, 32'(rdy), 32'h3);
        chk("stop_pv",    0, 32'(pv),  32'h1);
        @(negedge clk);
        stop = 1'b0; pr = 1'b1;
        #1;
        chk("drain_rdy",  0, 32'(rdy),  32'h0);
        chk("drain_busy", 0, 32'(busy), 32'h1);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            if (pv && pr) begin
                if (n < 4) begin
                    got_ch[n]  = pch;
                    got_dat[n] = pdat;
                end
                n++;
            end
            @(negedge clk);
            #1;
        end
        chk("drain_idle", 0, 32'(busy), 32'h0);
        chk("drain_pv",   0, 32'(pv),   32'h0);
        chk("drain_n",    0, 32'(n),    32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < n) begin
                chk("drain_ch",  k, 32'(got_ch[k]),  32'(k + 1));
                chk("drain_dat", k, 32'(got_dat[k]), 32'(vals[k + 1]));
            end
        end

        // Frame counter wrap from 0xFFFF.
        @(negedge clk);
        force dut.r_frame_count = 16'hFFFF;
        #1;
        release dut.r_frame_count;
        #1;
        chk("wrap_pre", 0, 32'(fc), 32'hFFFF);
        @(negedge clk);
        start = 1'b1; en = 4'h1; vld = 4'h0; pr = 1'b1;
        @(negedge clk);
        start = 1'b0; vld = 4'h1;
        @(negedge clk);
        vld = 4'h0;
        nfd = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (fd) begin
                nfd++;
                chk("wrap_fc_done", k, 32'(fc), 32'h0);
            end
            @(negedge clk);
        end
        #1;
        chk("wrap_ndone", 0, 32'(nfd), 32'd1);
        chk("wrap_fc",    0, 32'(fc),  32'h0);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (!busy) break;
            @(negedge clk);
        end
        chk("wrap_idle", 0, 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/channel_scheduler.md
CHANNEL_SCHEDULER -- requirements
Module: channel_scheduler

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of electrode channels sharing the pipeline.
REQ-002 SHALL have parameter DW, default 16, meaning signed sample width.
REQ-003 SHALL have parameter CHW, default $clog2(NCH), meaning channel tag width.
REQ-004 clk  in  1  single clock, one sample slot per cycle.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle pulse, IDLE->RUN.
REQ-007 stop  in  1  one-cycle pulse, RUN->DRAIN.
REQ-008 ch_enable  in  NCH  per-channel enable mask.
REQ-009 ch_valid  in  NCH  per-channel sample valid.
REQ-010 ch_data  in  NCH*DW  packed signed samples, channel i at bits [i*DW +: DW].
REQ-011 ch_ready  out  NCH  per-channel accept.
REQ-012 pipe_valid  out  1  sample valid toward the shared neural pipeline.
REQ-013 pipe_data  out  DW  signed sample.
REQ-014 pipe_chan  out  CHW  source channel tag.
REQ-015 pipe_ready  in  1  pipeline accept.
REQ-016 frame_done  out  1  one-cycle pulse per completed frame.
REQ-017 frame_count  out  16  completed-frame counter.
REQ-018 busy  out  1  high in RUN or DRAIN.

Function
REQ-019 SHALL implement FSM IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN on stop; DRAIN->IDLE when all holding slots and the output register are empty; start is ignored outside IDLE and stop outside RUN.
REQ-020 SHALL keep one holding slot per channel; ch_ready[i] = state==RUN & ch_enable[i] & slot i empty; a transfer occurs when ch_valid[i] & ch_ready[i].
REQ-021 SHALL clear slot i in the cycle ch_enable[i] is low (held sample discarded, never emitted).
REQ-022 SHALL grant at most one full, enabled slot per cycle, only when !pipe_valid | pipe_ready, in both RUN and DRAIN.
REQ-023 SHALL arbitrate round-robin: search starts at last_grant+1 mod NCH; last_grant updates only on a grant.
REQ-024 SHALL register the grant: pipe_data/pipe_chan load and pipe_valid rises the cycle after the grant; minimum latency from ch_valid transfer to pipe_valid is 2 cycles.
REQ-025 SHALL hold pipe_data/pipe_chan stable while pipe_valid & !pipe_ready; pipe_valid falls after acceptance only if no new grant occurs.
REQ-026 SHALL allow a slot to accept a new sample in the cycle after its grant; a channel that keeps ch_valid high SHALL be accepted at most every 2 cycles.
REQ-027 SHALL keep served mask S; a grant of channel i sets S[i]; frame complete when (S | grant) & ch_enable == ch_enable and ch_enable != 0.
REQ-028 On frame complete SHALL pulse frame_done the following cycle, clear S, and increment frame_count modulo 2^16 (0xFFFF->0x0000).
REQ-029 SHALL mask S with ch_enable every cycle; enable changes mid-frame are therefore allowed without a spurious frame_done.
REQ-030 SHALL never assert frame_done in IDLE, and SHALL clear S on IDLE->RUN.
REQ-031 SHALL preserve signed values bit-exactly (no arithmetic on data).

Reset
REQ-032 On rst low SHALL immediately force: state IDLE, all slots empty, S=0, last_grant=NCH-1 (channel 0 first), pipe_valid=0, pipe_data=0, pipe_chan=0, ch_ready=0, frame_done=0, frame_count=0, busy=0.
REQ-033 Reset asserted mid-transfer SHALL discard all held and in-flight samples; the design SHALL leave reset synchronously on the first clk edge after rst rises.

Structure
REQ-034 Shared package neural_pkg SHALL hold NCH/DW defaults, the state enum (IDLE, RUN, DRAIN), and the frame counter width.
REQ-035 Round-robin selection SHALL be a sub-module rr_arbiter (req NCH, last_grant in, grant one-hot + index out, combinational).

Verification
REQ-036 Reset, start, ch_enable=4'b1111, all ch_valid high with data 100,-200,300,-400, pipe_ready=1 -> pipe_chan 0,1,2,3 in order, data bit-exact, frame_done pulses the cycle after chan 3 is granted, frame_count=1.
REQ-037 pipe_ready=0 for 5 cycles with pipe_valid=1 -> pipe_data/pipe_chan unchanged across all 5 cycles; no slot lost; order resumes correctly.
REQ-038 ch_enable=4'b0101, channels 0 and 2 streaming -> only tags 0,2 alternate, frame_done every 2 grants; channel 1 ch_ready stays 0.
REQ-039 Preload frame_count to 0xFFFF via 65535 frames (or force) then one frame -> frame_count=0x0000, one frame_done.
REQ-040 stop with 3 samples held -> ch_ready drops next cycle, 3 samples emitted, busy falls and state IDLE after the last pipe acceptance.
REQ-041 rst low mid-stream with pipe_valid=1 -> pipe_valid=0 and frame_count=0 without a clock edge; after release and start, first grant is channel 0.
